dmem_responder: RTL and testbench

- Data-memory responder for the Y86-64 SEQ core.
- Sits on the far side of the memory-stage request interface. The core's memory stage issues one read (mrmovq, popq, ret) or one write (rmmovq, pushq, call) at a time; this block services it after a fixed latency and returns data plus an error flag (dmem_error, Y86 status ADR).
- Replaces the behavioural data_mem array with a handshaked, synthesizable store.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response channel between the SEQ core (master) and
// the data-memory responder (slave). Fixed 64-bit address and data.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Y86-64 SEQ data-memory responder: one outstanding access, fixed latency LAT.
// Define DMEM_ALIGN_CHECK_EN to also flag misaligned addresses as errors.
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int LAT   = 2,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [63:0] LIMIT    = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
  localparam bit          DIRECT   = (LAT == 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        latch_en;
  logic        commit;

  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic          acc_write;
  logic [63:0]   acc_addr;
  logic [63:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          mem_we;

  logic [63:0] mem [DEPTH];

  // With LAT==1 the access commits on the acceptance edge, so it must see the
  // live request rather than the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx = acc_addr[AW+2:3];

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = (acc_addr >= LIMIT) || (acc_addr[2:0] != 3'b000);
`else
  assign acc_err = (acc_addr >= LIMIT);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          latch_en = 1'b1;
          cnt_d    = CNT_INIT;
          if (DIRECT) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write reaching the array only at commit is what lets a reset during
  // BUSY drop the pending store.
  assign mem_we = commit && acc_write && !acc_err && rst_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_write || acc_err) ? 64'd0 : mem[acc_idx];
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_n and clearing
  // it would prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: LAT=2 instance driven from a vector
// table plus corner sequences, and a LAT=1 instance for back-to-back issue.
module tb_dmem_responder;

  localparam int LAT2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus2();
  dmem_responder_if bus1();

  dmem_responder #(.DEPTH(256), .LAT(LAT2), .AW(8)) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  dmem_responder #(.DEPTH(256), .LAT(1), .AW(8)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] rdata, input logic err);
    resp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag, input logic [63:0] got_rdata, input logic got_err);
    resp_t e;
    check({tag, " sb_pending"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " rdata"}, got_rdata, e.rdata);
      check({tag, " err"}, 64'(got_err), 64'(e.err));
    end
  endtask

  // Wait (bounded) for resp_valid on bus2; called on the negedge after acceptance.
  task automatic wait_resp2(input string tag);
    int lat;
    lat = 0;
    while (!bus2.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT2));
  endtask

  task automatic do_req2(input vec_t v, input string tag);
    int n;
    bus2.req_write = v.wr;
    bus2.req_addr  = v.addr;
    bus2.req_wdata = v.wdata;
    bus2.req_valid = 1'b1;
    n = 0;
    while (!bus2.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 64'(bus2.req_ready), 64'd1);
    push_exp(v.exp_rdata, v.exp_err);
    @(negedge clk);
    bus2.req_valid = 1'b0;
    wait_resp2(tag);
    pop_check(tag, bus2.resp_rdata, bus2.resp_err);
    bus2.resp_ready = 1'b1;
    @(negedge clk);
    bus2.resp_ready = 1'b0;
    check({tag, " valid_drop"}, 64'(bus2.resp_valid), 64'd0);
  endtask

  vec_t vec [14];
  vec_t ops1 [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0;   bus2.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.resp_ready = 1'b0;

    // Reset state, sampled while reset is held and again after release.
    repeat (3) @(negedge clk);
    check("rst req_ready", 64'(bus2.req_ready), 64'd1);
    check("rst resp_valid", 64'(bus2.resp_valid), 64'd0);
    check("rst resp_rdata", bus2.resp_rdata, 64'd0);
    check("rst resp_err", 64'(bus2.resp_err), 64'd0);
    check("rst1 req_ready", 64'(bus1.req_ready), 64'd1);
    check("rst1 resp_valid", 64'(bus1.resp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst req_ready", 64'(bus2.req_ready), 64'd1);
    check("post_rst resp_valid", 64'(bus2.resp_valid), 64'd0);

    // {write, addr, wdata, expected rdata, expected err}
    vec[0]  = '{1'b1, 64'h0,                 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0};
    vec[1]  = '{1'b1, 64'h10,                64'h1122_3344_5566_7788, 64'h0, 1'b0};
    vec[2]  = '{1'b0, 64'h10,                64'h0, 64'h1122_3344_5566_7788, 1'b0};
    vec[3]  = '{1'b1, 64'h18,                64'h0BAD_F00D_CAFE_0018, 64'h0, 1'b0};
    vec[4]  = '{1'b1, 64'h20,                64'd5,                   64'h0, 1'b0};
    vec[5]  = '{1'b1, 64'h800,               64'hAA,                  64'h0, 1'b1};
    vec[6]  = '{1'b0, 64'h800,               64'h0,                   64'h0, 1'b1};
    vec[7]  = '{1'b0, 64'h0,                 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0};
    vec[8]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                 64'h0, 1'b1};
    vec[9]  = '{1'b1, 64'h7F8,               64'h5555_AAAA_0000_7F8F, 64'h0, 1'b0};
    vec[10] = '{1'b0, 64'h7F8,               64'h0, 64'h5555_AAAA_0000_7F8F, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    vec[11] = '{1'b0, 64'h13,                64'h0,                   64'h0, 1'b1};
`else
    vec[11] = '{1'b0, 64'h13,                64'h0, 64'h1122_3344_5566_7788, 1'b0};
`endif
    vec[12] = '{1'b1, 64'h1000_0000_0000_0010, 64'h77,                64'h0, 1'b1};
    vec[13] = '{1'b0, 64'h10,                64'h0, 64'h1122_3344_5566_7788, 1'b0};

    for (int i = 0; i < 14; i++) do_req2(vec[i], $sformatf("vec%0d", i));

    // Backpressure: response held 5 cycles while a new request waits.
    bus2.req_write = 1'b0;
    bus2.req_addr  = 64'h18;
    bus2.req_valid = 1'b1;
    push_exp(64'h0BAD_F00D_CAFE_0018, 1'b0);
    @(negedge clk);
    bus2.req_write = 1'b1;
    bus2.req_wdata = 64'h99;
    wait_resp2("bp");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold%0d valid", i), 64'(bus2.resp_valid), 64'd1);
      check($sformatf("bp hold%0d rdata", i), bus2.resp_rdata, 64'h0BAD_F00D_CAFE_0018);
      check($sformatf("bp hold%0d req_ready", i), 64'(bus2.req_ready), 64'd0);
      @(negedge clk);
    end
    pop_check("bp", bus2.resp_rdata, bus2.resp_err);
    bus2.resp_ready = 1'b1;
    @(negedge clk);
    bus2.resp_ready = 1'b0;
    check("bp handshake valid", 64'(bus2.resp_valid), 64'd0);
    check("bp not_accepted_in_resp", 64'(bus2.req_ready), 64'd1);
    push_exp(64'h0, 1'b0);
    @(negedge clk);
    bus2.req_valid = 1'b0;
    check("bp held_req accepted", 64'(bus2.req_ready), 64'd0);
    wait_resp2("bp held");
    pop_check("bp held", bus2.resp_rdata, bus2.resp_err);
    bus2.resp_ready = 1'b1;
    @(negedge clk);
    bus2.resp_ready = 1'b0;
    do_req2('{1'b0, 64'h18, 64'h0, 64'h99, 1'b0}, "bp readback");

    // Reset during BUSY drops the pending write of 9 to 0x20.
    bus2.req_write = 1'b1;
    bus2.req_addr  = 64'h20;
    bus2.req_wdata = 64'd9;
    bus2.req_valid = 1'b1;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    check("midrst busy", 64'(bus2.req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst req_ready", 64'(bus2.req_ready), 64'd1);
    check("midrst resp_valid", 64'(bus2.resp_valid), 64'd0);
    check("midrst resp_rdata", bus2.resp_rdata, 64'd0);
    check("midrst resp_err", 64'(bus2.resp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req2('{1'b0, 64'h20, 64'h0, 64'd5, 1'b0}, "midrst readback");

    // LAT=1: request and resp_ready held high; push/pop at 0xF8 and 0xF0.
    ops1[0] = '{1'b1, 64'hF8, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0};
    ops1[1] = '{1'b0, 64'hF8, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0};
    ops1[2] = '{1'b1, 64'hF0, 64'h42,                  64'h0, 1'b0};
    ops1[3] = '{1'b0, 64'hF0, 64'h0,                   64'h42, 1'b0};
    begin
      int k;
      int last_acc;
      k = 0;
      last_acc = -100;
      bus1.resp_ready = 1'b1;
      bus1.req_valid  = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
        if (bus1.resp_valid) begin
          check($sformatf("lat1 resp%0d latency", k - 1), 64'(cyc - last_acc), 64'd1);
          pop_check($sformatf("lat1 resp%0d", k - 1), bus1.resp_rdata, bus1.resp_err);
        end
        if (bus1.req_ready) begin
          if (k < 4) begin
            bus1.req_write = ops1[k].wr;
            bus1.req_addr  = ops1[k].addr;
            bus1.req_wdata = ops1[k].wdata;
            push_exp(ops1[k].exp_rdata, ops1[k].exp_err);
            if (k > 0) check($sformatf("lat1 issue%0d interval", k), 64'(cyc - last_acc), 64'd2);
            last_acc = cyc;
            k++;
          end else begin
            bus1.req_valid = 1'b0;
          end
        end
        @(negedge clk);
      end
      bus1.resp_ready = 1'b0;
      check("lat1 accepted", 64'(k), 64'd4);
    end
    check("sb drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
